mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline. It is the sending end of the ms_to_ws valid/allowin handshake into WB.
//  Latches the EX->MEM bus and aligns and extends load data read from the synchronous data SRAM.
//  Presents {gr_we, dest, final_result, pc} on ms_to_ws_bus, and reports its in-flight destination to ID for hazard checks.
// PARAMETERS
//  none; bus widths are `ES_TO_MS_BUS_WD (74) and `MS_TO_WS_BUS_WD (70) from mycpu.h
// PORTS
//  clk              in   1    clock; all state updates on posedge
//  reset            in   1    synchronous, active-high
//  ms_allowin       out  1    MEM can accept from EX this cycle
//  es_to_ms_valid   in   1    EX holds a valid instruction
//  es_to_ms_bus     in   74   {load_op[2:0],res_from_mem,gr_we,dest[4:0],alu_result[31:0],pc[31:0]}, bits 73:0
//  ws_allowin       in   1    WB can accept this cycle
//  ms_to_ws_valid   out  1    MEM holds a valid instruction for WB
//  ms_to_ws_bus     out  70   {gr_we[69],dest[68:64],final_result[63:32],pc[31:0]}
//  data_sram_rdata  in   32   SRAM read data; valid ONLY in first cycle after instruction enters MEM
//  ms_dst_reg       out  5    ms_valid&&gr_we ? dest : 0
//  ms_fwd_bus       out  38   {fwd_valid,dest[4:0],final_result[31:0]}; present only with MS_FWD_EN
// BEHAVIOUR
//  - ms_ready_go=1; ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go.
//  - ms_valid: reset->0; else if ms_allowin, ms_valid <= es_to_ms_valid. Bus reg loads on es_to_ms_valid && ms_allowin.
//  - Reset values: ms_valid=0, bus reg=0, hold_valid=0, fresh=0 => ms_to_ws_valid=0, ms_dst_reg=0, fwd_valid=0.
//  - Latency: 1 cycle EX->WB-visible; full throughput (1 instr/cycle) when ws_allowin=1.
//  - fresh flag: set to 1 in the cycle after a load into MEM, 0 otherwise (reset->0).
//  - Load-data hold: if fresh && !ws_allowin, capture data_sram_rdata into hold_data and set hold_valid.
//    Clear hold_valid when the instruction leaves (ms_to_ws_valid && ws_allowin) or on reset.
//    Effective rdata = hold_valid ? hold_data : data_sram_rdata.
//  - Alignment, off = alu_result[1:0]. load_op: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW.
//    LW ignores off. LB/LBU select byte off. LH/LHU select half off[1] and ignore off[0].
//    LB/LH sign-extend; LBU/LHU zero-extend.
//    Misaligned-address exceptions are not raised here.
//  - final_result = res_from_mem ? aligned_load : alu_result. gr_we and dest pass through unchanged.
//  - Simultaneous leave+enter: a new instruction may enter in the same cycle the old one leaves.
//    hold_valid clears and fresh re-arms for the new one.
//  - Reset mid-stall: all valid/hold state cleared next edge; in-flight instruction discarded.
// CONFIGURATION
//  MS_FWD_EN defined: ms_fwd_bus port present.
//    fwd_valid = ms_valid && gr_we && !res_from_mem && dest!=0, letting ID bypass ALU results from MEM.
//  MS_FWD_EN undefined: port absent; ID relies on ms_dst_reg stall only. All other behaviour identical.
// STRUCTURE
//  mycpu.h: `ES_TO_MS_BUS_WD, `MS_TO_WS_BUS_WD, `MS_FWD_BUS_WD, and load_op encodings.
//  Load_op encodings are `LOAD_LW, `LOAD_LB, `LOAD_LBU, `LOAD_LH, `LOAD_LHU.
//  One combinational sub-module, load_align: (rdata[31:0], off[1:0], load_op[2:0]) -> aligned[31:0].
//  Handshake, fresh and hold registers stay in the top level.
// TESTING
//  1 LB, alu_result=0x1003, rdata=0x80FF1234, ws_allowin=1 -> next cycle final_result=0xFFFFFF80, gr_we/dest passed.
//  2 LHU off=2, rdata=0x80010000 -> 0x00008001; LH same -> 0xFFFF8001; LW off=2 -> 0x80010000.
//  3 LW enters, rdata=0x12345678; ws_allowin=0 for 3 cycles; rdata changes to 0xDEADBEEF.
//    -> ms_allowin=0 throughout; on release ms_to_ws_bus final_result=0x12345678.
//  4 Non-loads back-to-back, ws_allowin=1 for 10 cycles -> 10 consecutive ms_to_ws_valid.
//    final_result=alu_result each time; ms_dst_reg tracks dest.
//  5 Reset asserted during test 3 stall -> next cycle ms_to_ws_valid=0, ms_dst_reg=0.
//    Next LW after reset uses fresh rdata, not stale hold_data.
//  6 MS_FWD_EN: ADD dest=8 -> fwd_valid=1, data=alu_result; LW dest=8 -> fwd_valid=0; dest=0 -> fwd_valid=0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load opcodes and bus layouts.
// The optional forwarding port is controlled by the MS_FWD_EN macro.
package mem_access_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FWD_BUS_WD   = 38;

    // Load operation encodings; codes 5-7 are not defined and behave as LW.
    localparam logic [2:0] LOAD_LW  = 3'd0;
    localparam logic [2:0] LOAD_LB  = 3'd1;
    localparam logic [2:0] LOAD_LBU = 3'd2;
    localparam logic [2:0] LOAD_LH  = 3'd3;
    localparam logic [2:0] LOAD_LHU = 3'd4;

    // Layout of the EX->MEM bus, MSB first.
    typedef struct packed {
        logic [2:0]  load_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    // Layout of the MEM->WB bus, MSB first.
    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load-data alignment: picks the byte/half addressed by the low
// address bits and sign- or zero-extends it to 32 bits.
module load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  load_op,
    output logic [31:0] aligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane selected by the full offset.
    always_comb begin
        w_byte = rdata[7:0];
        case (off)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    // Halfword lane only looks at off[1]; off[0] is ignored for halves.
    assign w_half = off[1] ? rdata[31:16] : rdata[15:0];

    // Extension by load type; undefined codes fall through to a full word.
    always_comb begin
        aligned = rdata;
        case (load_op)
            LOAD_LB:  aligned = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: aligned = {24'd0, w_byte};
            LOAD_LH:  aligned = {{16{w_half[15]}}, w_half};
            LOAD_LHU: aligned = {16'd0, w_half};
            default:  aligned = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline: latches the EX->MEM bus, aligns load data
// from the synchronous data SRAM and hands {gr_we, dest, result, pc} to WB.
// SRAM read data is only valid in the first cycle an instruction sits here, so
// it is captured into a hold register if WB stalls during that cycle.
// Define MS_FWD_EN to add the ms_fwd_bus port for ALU-result bypassing to ID.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
`ifdef MS_FWD_EN
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
`endif
    output logic [4:0]                 ms_dst_reg
);

    logic        r_ms_valid;
    es_to_ms_t   r_bus;
    logic        r_fresh;
    logic        r_hold_valid;
    logic [31:0] r_hold_data;

    logic        w_ms_ready_go;
    logic        w_enter;
    logic        w_leave;
    logic [31:0] w_rdata;
    logic [31:0] w_aligned;
    logic [31:0] w_final_result;
    ms_to_ws_t   w_out;

    // MEM never needs extra cycles: the SRAM result is already available.
    assign w_ms_ready_go  = 1'b1;
    assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
    assign w_enter        = es_to_ms_valid && ms_allowin;
    assign w_leave        = ms_to_ws_valid && ws_allowin;

    // Pipeline valid, payload latch and the first-cycle (fresh) marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
            r_bus      <= '0;
            r_fresh    <= 1'b0;
        end else begin
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (w_enter) begin
                r_bus <= es_to_ms_bus;
            end
            r_fresh <= w_enter;
        end
    end

    // Preserve the one-cycle SRAM data when WB stalls, release on departure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= 32'd0;
        end else if (w_leave) begin
            r_hold_valid <= 1'b0;
        end else if (r_fresh && !ws_allowin) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= data_sram_rdata;
        end
    end

    assign w_rdata = r_hold_valid ? r_hold_data : data_sram_rdata;

    load_align u_load_align (
        .rdata   (w_rdata),
        .off     (r_bus.alu_result[1:0]),
        .load_op (r_bus.load_op),
        .aligned (w_aligned)
    );

    assign w_final_result = r_bus.res_from_mem ? w_aligned : r_bus.alu_result;

    assign w_out.gr_we        = r_bus.gr_we;
    assign w_out.dest         = r_bus.dest;
    assign w_out.final_result = w_final_result;
    assign w_out.pc           = r_bus.pc;
    assign ms_to_ws_bus       = w_out;

    assign ms_dst_reg = (r_ms_valid && r_bus.gr_we) ? r_bus.dest : 5'd0;

`ifdef MS_FWD_EN
    // Only ALU results can be bypassed; loads must still stall in ID.
    logic w_fwd_valid;
    assign w_fwd_valid = r_ms_valid && r_bus.gr_we && !r_bus.res_from_mem
                         && (r_bus.dest != 5'd0);
    assign ms_fwd_bus  = {w_fwd_valid, r_bus.dest, w_final_result};
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes the expected WB bus
// word, a negedge monitor pops and compares whenever MEM hands off to WB.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic [4:0]  ms_dst_reg;
`ifdef MS_FWD_EN
    logic [37:0] ms_fwd_bus;
`endif

    int checks;
    int failures;
    int valid_count;
    logic [69:0] exp_q[$];

    mem_access_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
`ifdef MS_FWD_EN
        .ms_fwd_bus      (ms_fwd_bus),
`endif
        .ms_dst_reg      (ms_dst_reg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [73:0] mk_in(input logic [2:0] op, input logic rfm,
                                          input logic we, input logic [4:0] dest,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {op, rfm, we, dest, alu, pc};
    endfunction

    function automatic logic [69:0] mk_out(input logic we, input logic [4:0] dest,
                                           input logic [31:0] res, input logic [31:0] pc);
        return {we, dest, res, pc};
    endfunction

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic apply(input logic v, input logic [73:0] bus,
                         input logic [31:0] rd, input logic wa);
        es_to_ms_valid  = v;
        es_to_ms_bus    = bus;
        data_sram_rdata = rd;
        ws_allowin      = wa;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every WB handoff must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected actual=%h required=no_output", ms_to_ws_bus);
            end else begin
                logic [69:0] e;
                e = exp_q.pop_front();
                if (ms_to_ws_bus !== e) begin
                    failures++;
                    $display("FAIL wb_bus actual=%h required=%h", ms_to_ws_bus, e);
                end else begin
                    $display("ok   wb_bus value=%h", ms_to_ws_bus);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [73:0] b_instr;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        apply(1'b0, 74'd0, 32'd0, 1'b1);
        tick();
        tick();

        // Reset state
        chk("rst_valid", ms_to_ws_valid, 0);
        chk("rst_allowin", ms_allowin, 1);
        chk("rst_dst", ms_dst_reg, 0);
        chk("rst_bus", ms_to_ws_bus, 0);
        reset = 1'b0;

        // Test 1: LB off=3 sign-extends 0x80
        apply(1'b1, mk_in(3'd1, 1'b1, 1'b1, 5'd3, 32'h1003, 32'h100), 32'd0, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd3, 32'hFFFFFF80, 32'h100));
        tick();
        apply(1'b0, 74'd0, 32'h80FF1234, 1'b1);
        chk("t1_valid", ms_to_ws_valid, 1);
        chk("t1_dst", ms_dst_reg, 3);
        tick();

        // Test 2: back-to-back loads of each kind
        apply(1'b1, mk_in(3'd4, 1'b1, 1'b1, 5'd4, 32'h2002, 32'h104), 32'd0, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd4, 32'h00008001, 32'h104));
        tick();
        apply(1'b1, mk_in(3'd3, 1'b1, 1'b1, 5'd5, 32'h2006, 32'h108), 32'h80010000, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd5, 32'hFFFF8001, 32'h108));
        tick();
        apply(1'b1, mk_in(3'd0, 1'b1, 1'b1, 5'd6, 32'h200A, 32'h10C), 32'h80010000, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd6, 32'h80010000, 32'h10C));
        tick();
        apply(1'b1, mk_in(3'd2, 1'b1, 1'b1, 5'd7, 32'h2001, 32'h110), 32'h80010000, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd7, 32'h00000080, 32'h110));
        tick();
        apply(1'b1, mk_in(3'd7, 1'b1, 1'b1, 5'd9, 32'h3001, 32'h114), 32'h000080FF, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd9, 32'hA5A55A5A, 32'h114));
        tick();
        apply(1'b1, mk_in(3'd0, 1'b0, 1'b0, 5'd10, 32'h0000ABCD, 32'h118), 32'hA5A55A5A, 1'b1);
        exp_q.push_back(mk_out(1'b0, 5'd10, 32'h0000ABCD, 32'h118));
        tick();
        apply(1'b0, 74'd0, 32'hFFFFFFFF, 1'b1);
        chk("t2_dst_nowe", ms_dst_reg, 0);
        tick();

        // Test 3: WB stall on a fresh LW, second instruction waits then enters
        apply(1'b1, mk_in(3'd0, 1'b1, 1'b1, 5'd11, 32'h4000, 32'h200), 32'd0, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd11, 32'h12345678, 32'h200));
        tick();
        b_instr = mk_in(3'd3, 1'b1, 1'b1, 5'd12, 32'h4002, 32'h204);
        apply(1'b1, b_instr, 32'h12345678, 1'b0);
        exp_q.push_back(mk_out(1'b1, 5'd12, 32'hFFFF9ABC, 32'h204));
        chk("t3_allowin_c0", ms_allowin, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, b_instr, 32'hDEADBEEF, 1'b0);
            chk("t3_allowin_stall", ms_allowin, 0);
            chk("t3_valid_stall", ms_to_ws_valid, 1);
            tick();
        end
        apply(1'b1, b_instr, 32'hDEADBEEF, 1'b1);
        chk("t3_allowin_release", ms_allowin, 1);
        tick();
        apply(1'b0, 74'd0, 32'h9ABC0000, 1'b1);
        chk("t3_dst_new", ms_dst_reg, 12);
        tick();

        // Test 5: reset during stall discards the held instruction
        apply(1'b1, mk_in(3'd0, 1'b1, 1'b1, 5'd13, 32'h5000, 32'h300), 32'd0, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd13, 32'h12345678, 32'h300));
        tick();
        apply(1'b0, 74'd0, 32'h12345678, 1'b0);
        tick();
        apply(1'b0, 74'd0, 32'hDEADBEEF, 1'b0);
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("t5_valid_after_rst", ms_to_ws_valid, 0);
        chk("t5_dst_after_rst", ms_dst_reg, 0);
        reset = 1'b0;
        apply(1'b1, mk_in(3'd0, 1'b1, 1'b1, 5'd14, 32'h5004, 32'h304), 32'd0, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd14, 32'hCAFEF00D, 32'h304));
        tick();
        apply(1'b0, 74'd0, 32'hCAFEF00D, 1'b1);
        tick();

        // Test 4: ten non-loads at full throughput
        valid_count = 0;
        for (int i = 0; i < 10; i++) begin
            logic [4:0]  d;
            logic [31:0] a;
            logic [31:0] p;
            d = 5'(i + 16);
            a = 32'h1000 * i + 32'h11;
            p = 32'h400 + 32'(4 * i);
            apply(1'b1, mk_in(3'd0, 1'b0, 1'b1, d, a, p), 32'hFFFFFFFF, 1'b1);
            exp_q.push_back(mk_out(1'b1, d, a, p));
            if (i > 0) begin
                chk("t4_dst", ms_dst_reg, 70'(i + 15));
            end
            if (ms_to_ws_valid) valid_count++;
            tick();
        end
        apply(1'b0, 74'd0, 32'hFFFFFFFF, 1'b1);
        chk("t4_dst_last", ms_dst_reg, 25);
        if (ms_to_ws_valid) valid_count++;
        tick();
        chk("t4_valid_count", valid_count, 10);

`ifdef MS_FWD_EN
        // Test 6: forwarding bus
        apply(1'b1, mk_in(3'd0, 1'b0, 1'b1, 5'd8, 32'h55, 32'h500), 32'd0, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd8, 32'h55, 32'h500));
        tick();
        apply(1'b1, mk_in(3'd0, 1'b1, 1'b1, 5'd8, 32'h600, 32'h504), 32'd0, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd8, 32'h77777777, 32'h504));
        chk("t6_fwd_add", ms_fwd_bus, {1'b1, 5'd8, 32'h55});
        tick();
        apply(1'b1, mk_in(3'd0, 1'b0, 1'b1, 5'd0, 32'h99, 32'h508), 32'h77777777, 1'b1);
        exp_q.push_back(mk_out(1'b1, 5'd0, 32'h99, 32'h508));
        chk("t6_fwd_load", ms_fwd_bus[37], 0);
        tick();
        apply(1'b0, 74'd0, 32'd0, 1'b1);
        chk("t6_fwd_dest0", ms_fwd_bus[37], 0);
        tick();
`endif

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick();
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
